// File: rtl/mem_access.sv
// mem_access -- data-memory access stage (MEM), directly downstream of EX.
//
// Runs one request/ready bus transaction per load/store held in the MEM
// stage. It stalls the pipeline while the transaction is outstanding, and
// formats the returned word into aligned, sign/zero-extended load data.
// A watchdog aborts a transaction that has not completed after TIMEOUT
// WAIT cycles.
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to reject misaligned
// halfword/word accesses. A rejected access raises a one-cycle `misalign`
// pulse and issues no bus request. When the macro is undefined, `misalign`
// is tied low and the low address bits are ignored for H/W accesses.
//
// Parameters
//   TIMEOUT           WAIT cycles without bus_ready before abort (1..255)
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   valid_mem         MEM stage holds a valid instruction
//   MemRead_mem       load
//   MemWrite_mem      store
//   funct3_mem        size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALUResult_mem     byte address
//   MemWriteData_mem  right-aligned store data
//   bus_req/we/addr/wdata/wstrb  registered bus request outputs
//   bus_ready, bus_rdata         slave completion and read data
//   MemDout_mem       registered, formatted load data
//   stall_mem         combinational pipeline freeze
//   bus_err           one-cycle pulse on watchdog abort
//   misalign          one-cycle pulse on a misaligned access (macro only)
module mem_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_mem,
  input  logic        MemRead_mem,
  input  logic        MemWrite_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [31:0] ALUResult_mem,
  input  logic [31:0] MemWriteData_mem,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic [31:0] MemDout_mem,
  output logic        stall_mem,
  output logic        bus_err,
  output logic        misalign
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  wd_cnt;
  logic [1:0]  lane_q;   // address byte offset of the access in flight
  logic [2:0]  f3_q;     // funct3 of the access in flight
  logic        rd_q;     // access in flight is a load

  logic        access_req;
  logic        access_start;
  logic        misaligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = ((funct3_mem == 3'b001 || funct3_mem == 3'b101) && ALUResult_mem[0])
                    || (funct3_mem == 3'b010 && ALUResult_mem[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign access_req   = valid_mem & (MemRead_mem | MemWrite_mem) & (state == S_IDLE);
  assign access_start = access_req & ~misaligned;
  assign stall_mem    = access_start | (state == S_WAIT);

  // Store lane replication and byte enables.
  always_comb begin
    st_wdata = MemWriteData_mem;
    st_wstrb = 4'b1111;
    case (funct3_mem[1:0])
      2'b00: begin
        st_wdata = {4{MemWriteData_mem[7:0]}};
        st_wstrb = 4'b0001 << ALUResult_mem[1:0];
      end
      2'b01: begin
        st_wdata = {2{MemWriteData_mem[15:0]}};
        st_wstrb = 4'b0011 << {ALUResult_mem[1], 1'b0};
      end
      default: begin
        st_wdata = MemWriteData_mem;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Load lane selection and extension from the latched offset/funct3.
  always_comb begin
    ld_byte = bus_rdata[7:0];
    case (lane_q)
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wd_cnt      <= '0;
      lane_q      <= '0;
      f3_q        <= '0;
      rd_q        <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_wstrb   <= '0;
      MemDout_mem <= '0;
      bus_err     <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        S_IDLE: begin
          // Clearing here is equivalent to clearing on entry to WAIT.
          wd_cnt <= '0;
          if (access_start) begin
            bus_req   <= 1'b1;
            bus_we    <= MemWrite_mem;
            bus_addr  <= {ALUResult_mem[31:2], 2'b00};
            bus_wdata <= st_wdata;
            bus_wstrb <= MemWrite_mem ? st_wstrb : 4'b0000;
            lane_q    <= ALUResult_mem[1:0];
            f3_q      <= funct3_mem;
            rd_q      <= MemRead_mem;
            state     <= S_WAIT;
          end else if (access_req & misaligned) begin
            MemDout_mem <= '0;
          end
        end
        S_WAIT: begin
          wd_cnt <= wd_cnt + 8'd1;
          // Completion takes priority over the watchdog on the same edge.
          if (bus_ready) begin
            bus_req <= 1'b0;
            if (rd_q) MemDout_mem <= ld_data;
            state <= S_DONE;
          end else if (wd_cnt == TO_LAST) begin
            bus_req     <= 1'b0;
            MemDout_mem <= '0;
            bus_err     <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign <= 1'b0;
    else        misalign <= access_req & misaligned;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule
